onehot_event_counter: RTL

Downstream consumer of the 3-to-8 decoder's one-hot output. It samples the 8-bit one-hot word on a valid strobe and keeps a saturating hit counter per channel. It also tracks the last channel hit and flags malformed (multi-hot) words. A registered readout port exposes any counter to a host or to debug logic.

---
 rtl/onehot_event_counter_pkg.sv | 25 ++
 rtl/onehot_event_counter_if.sv | 28 ++
 rtl/onehot_event_counter_sat_cnt.sv | 30 +++
 rtl/onehot_event_counter.sv | 97 +++++++++
 4 files changed

// File: rtl/onehot_event_counter_pkg.sv
// Shared constants and helpers for the one-hot event counter.
// Package name: onehot_cnt_pkg.
package onehot_cnt_pkg;

  localparam int CH_NUM   = 8;
  localparam int CH_IDX_W = 3;

  // Encoded index of the highest set bit (0 when the word is all-zero).
  function automatic logic [CH_IDX_W-1:0] onehot_to_idx(input logic [CH_NUM-1:0] word);
    logic [CH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (word[i]) begin
        idx = i[CH_IDX_W-1:0];
      end
    end
    return idx;
  endfunction

  // True when exactly one bit of the word is set.
  function automatic logic is_onehot(input logic [CH_NUM-1:0] word);
    return (word != '0) && ((word & (word - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/onehot_event_counter_if.sv
// Host-side bundle of the one-hot event counter: sample input, clear,
// readout select and all status outputs.
interface onehot_event_counter_if #(
  parameter int CNT_W = 8
);
  import onehot_cnt_pkg::*;

  logic [CH_NUM-1:0]   i_onehot;
  logic                i_onehot_vld;
  logic                i_clr;
  logic [CH_IDX_W-1:0] i_rd_sel;
  logic [CNT_W-1:0]    o_rd_data;
  logic [CH_NUM-1:0]   o_sat;
  logic [CH_IDX_W-1:0] o_last_ch;
  logic                o_hit;
  logic                o_err;

  modport master (
    output i_onehot, i_onehot_vld, i_clr, i_rd_sel,
    input  o_rd_data, o_sat, o_last_ch, o_hit, o_err
  );

  modport slave (
    input  i_onehot, i_onehot_vld, i_clr, i_rd_sel,
    output o_rd_data, o_sat, o_last_ch, o_hit, o_err
  );

endinterface

// File: rtl/onehot_event_counter_sat_cnt.sv
// Saturating per-channel hit counter; sat is high while the count sits at
// its maximum, which stays true until a clear since the count never drops.
module onehot_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_reg;

  // Count up on inc, hold at maximum, clear has priority over inc.
  always_ff @(posedge i_clk) begin
    if (i_rst || clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
  assign sat = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/onehot_event_counter.sv
// One-hot event counter: samples the decoder word, counts hits per channel
// with saturation, tracks the last channel and exposes a registered readout.
// Optional macro ONEHOT_EVENT_COUNTER_CHK_EN: reject multi-hot words and
// raise a sticky error instead of counting every set bit.
module onehot_event_counter
  import onehot_cnt_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  onehot_event_counter_if.slave bus
);

  logic [CH_NUM-1:0]   s1_word_reg;
  logic                s1_vld_reg;
  logic                clr_all;
  logic                count_en;
  logic                err_next;
  logic [CH_NUM-1:0]   inc_vec;
  logic [CH_NUM-1:0]   sat_vec;
  logic [CNT_W-1:0]    cnt_arr [CH_NUM];
  logic [CH_IDX_W-1:0] last_ch_reg;
  logic                hit_reg;
  logic                err_reg;
  logic [CNT_W-1:0]    rd_data_reg;

  assign clr_all = i_rst | bus.i_clr;

  // Stage 1 capture; a clear drops both the arriving word and any held one.
  always_ff @(posedge i_clk) begin
    if (clr_all) begin
      s1_word_reg <= '0;
      s1_vld_reg  <= 1'b0;
    end else begin
      s1_word_reg <= bus.i_onehot;
      s1_vld_reg  <= bus.i_onehot_vld;
    end
  end

  // Stage 2 classifier: decide whether the held word counts and flag errors.
  always_comb begin
    count_en = 1'b0;
    err_next = 1'b0;
`ifdef ONEHOT_EVENT_COUNTER_CHK_EN
    count_en = s1_vld_reg && is_onehot(s1_word_reg);
    err_next = err_reg || (s1_vld_reg && (s1_word_reg != '0) && !is_onehot(s1_word_reg));
`else
    count_en = s1_vld_reg && (s1_word_reg != '0);
`endif
    inc_vec = count_en ? s1_word_reg : '0;
  end

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      onehot_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .clr   (clr_all),
        .inc   (inc_vec[gi]),
        .cnt   (cnt_arr[gi]),
        .sat   (sat_vec[gi])
      );
    end
  endgenerate

  // Event status: hit pulse, last counted channel and sticky error.
  always_ff @(posedge i_clk) begin
    if (clr_all) begin
      last_ch_reg <= '0;
      hit_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      hit_reg <= count_en;
      err_reg <= err_next;
      if (count_en) begin
        last_ch_reg <= onehot_to_idx(s1_word_reg);
      end
    end
  end

  // Registered readout without bypass; only reset zeroes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= cnt_arr[bus.i_rd_sel];
    end
  end

  assign bus.o_rd_data = rd_data_reg;
  assign bus.o_sat     = sat_vec;
  assign bus.o_last_ch = last_ch_reg;
  assign bus.o_hit     = hit_reg;
  assign bus.o_err     = err_reg;

endmodule
